// File: rtl/counter_ctrl_pkg.sv
// Shared types and encodings for the counter_ctrl sequencer.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDwell
    } state_e;

    // cnt_ent codes understood by up_counter
    localparam logic [1:0] CNT_UP   = 2'b10;
    localparam logic [1:0] CNT_DN   = 2'b01;
    localparam logic [1:0] CNT_HOLD = 2'b00;

    // Completion status reported alongside done
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ABORT   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/counter_ctrl_timer.sv
// Loadable down-counter with a zero flag; shared by the dwell hold and the RUN timeout.
module counter_ctrl_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] val_q;

    // Load has priority over decrement; the count saturates at zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q <= '0;
        end else if (load) begin
            val_q <= load_val;
        end else if (dec && (val_q != '0)) begin
            val_q <= val_q - 1'b1;
        end
    end

    assign zero = (val_q == '0);

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for up_counter: steps cnt_ent until cnt hits the target,
// holds for the dwell time, then pulses done with a status code.
// Optional RUN timeout enabled by defining CNT_CTRL_TIMEOUT_EN.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned TIMEOUT = 80
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [CNT_W-1:0]   cmd_target,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    input  logic [CNT_W-1:0]   cnt,
    output logic [1:0]         cnt_ent,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status
);

    // Wide enough for either a dwell value or the RUN timeout
    localparam int unsigned TMR_W = max_w(DWELL_W, $clog2(TIMEOUT));

    state_e               state_q, state_d;
    logic                 dir_q;
    logic [CNT_W-1:0]     target_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic                 done_q, done_d;
    logic [1:0]           status_q, status_d;

    logic                 accept;
    logic                 at_target;
    logic                 timeout_hit;
    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_dec;
    logic                 tmr_zero;

    assign cmd_ready = (state_q == StIdle) && rst;
    assign accept    = cmd_valid && cmd_ready;
    assign at_target = (cnt == target_q);
    assign busy      = (state_q == StRun) || (state_q == StDwell);
    assign done      = done_q;
    assign status    = status_q;

`ifdef CNT_CTRL_TIMEOUT_EN
    assign timeout_hit = (state_q == StRun) && tmr_zero;
`else
    assign timeout_hit = 1'b0;
`endif

    counter_ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // State, completion pulse and latched command fields
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            done_q   <= 1'b0;
            status_q <= ST_OK;
            dir_q    <= 1'b0;
            target_q <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            status_q <= status_d;
            if (accept) begin
                dir_q    <= cmd_dir;
                target_q <= cmd_target;
                dwell_q  <= cmd_dwell;
            end
        end
    end

    // Next state, counter enable and timer control; target beats abort beats timeout
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        status_d = ST_OK;
        cnt_ent  = CNT_HOLD;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
`ifdef CNT_CTRL_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT - 1);
`endif
                end
            end
            StRun: begin
                if (at_target) begin
                    if (dwell_q != '0) begin
                        state_d  = StDwell;
                        tmr_load = 1'b1;
                        // Loaded with dwell-1 so zero is reached on the last dwell cycle
                        tmr_val  = TMR_W'(dwell_q - 1'b1);
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else if (abort) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = ST_ABORT;
                end else if (timeout_hit) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = ST_TIMEOUT;
                end else begin
                    cnt_ent = dir_q ? CNT_UP : CNT_DN;
`ifdef CNT_CTRL_TIMEOUT_EN
                    tmr_dec = 1'b1;
`endif
                end
            end
            StDwell: begin
                if (tmr_zero) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (abort) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = ST_ABORT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Never move the counter on the edge that resets the controller
        if (!rst) begin
            cnt_ent = CNT_HOLD;
        end
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Command-driven sequencer for the 6-bit `up_counter`. It accepts move commands over a valid/ready handshake: a direction, a target value and a dwell time. It drives the counter's `cnt_ent` so the counter stops exactly on the target, holds it for the dwell time, then reports completion. It sits between a host/control FSM and `up_counter`, and is the only driver of `cnt_ent`.

## Interface
- `CNT_W`, 6: counter width; must match `up_counter`.
- `DWELL_W`, 8: width of the dwell field.
- `TIMEOUT`, 80: maximum RUN cycles before abort. Used only with `CNT_CTRL_TIMEOUT_EN`; must be greater than 2^CNT_W.
- `clk`  in  1  : single clock; all logic on the rising edge.
- `rst`  in  1  : synchronous reset, active-low.
- `cmd_valid`  in  1  : command present.
- `cmd_ready`  out  1  : controller can accept a command; combinational, equals (state==IDLE && rst).
- `cmd_dir`  in  1  : 1 = count up, 0 = count down.
- `cmd_target`  in  CNT_W  : value at which counting stops.
- `cmd_dwell`  in  DWELL_W  : hold cycles after the target is reached.
- `abort`  in  1  : cancel the active command.
- `cnt`  in  CNT_W  : counter output, fed back from `up_counter`.
- `cnt_ent`  out  2  : to `up_counter`: 2'b10 = up, 2'b01 = down, 2'b00 = hold; 2'b11 is never driven.
- `busy`  out  1  : state is RUN or DWELL.
- `done`  out  1  : one-cycle registered completion pulse.
- `status`  out  2  : valid while `done`=1: 00 = ok, 01 = aborted, 10 = timeout.

## Operation
- The counter changes at each rising edge according to the `cnt_ent` sampled there; it wraps modulo 2^CNT_W in both directions.
- States and transitions:
  - IDLE: `cnt_ent`=00. A handshake (`cmd_valid && cmd_ready`) latches dir/target/dwell and moves to RUN.
  - RUN: `cnt_ent` is combinational. It is the dir code while `cnt != target`, and 00 when `cnt == target`.
    - On `cnt == target`: go to DWELL if dwell > 0, else go to IDLE with `done`=1, `status`=00.
  - DWELL: `cnt_ent`=00; a down-counter loaded with dwell expires after exactly dwell cycles, then go to IDLE with `done`=1, `status`=00.
- Wrap-around: the direction is always honoured. Up from 60 to 2 takes 6 steps through 63→0; it never reverses to take the shorter path.
- Target equal to `cnt` at accept: zero steps; RUN lasts one cycle with `cnt_ent`=00.
- `abort` during RUN or DWELL: `cnt_ent` is forced to 00 combinationally in that same cycle; next state IDLE, `done`=1, `status`=01.
- `abort` in IDLE is ignored.
- Target reached and `abort` in the same cycle: completion wins, `status`=00.
- Commands are not queued. `cmd_valid` while busy simply waits for `cmd_ready`.
- Back-to-back commands: a new command is accepted in the same cycle `done` is high.

## Timing
- Reset (`rst`=0 at an edge):
  - next state IDLE;
  - `cnt_ent`=00, `busy`=0, `done`=0, `status`=00;
  - `cmd_ready`=0 while `rst` is low.
  - A command in flight is dropped with no `done`.
- Accept at edge E0, n steps needed:
  - `cnt_ent` is active for cycles E0..E0+n-1;
  - `cnt` equals the target after edge E0+n;
  - with dwell=0, `done` is high in cycle E0+n+1.
- Dwell d>0: DWELL occupies d cycles and `done` follows in the next cycle. Total latency from accept to `done` is n+d+1 cycles (n+1 if d=0).
- `done` and `status` are registered and high for exactly one cycle.

## Configuration
- `CNT_CTRL_TIMEOUT_EN` defined:
  - a RUN-cycle counter clears on entry to RUN;
  - if RUN lasts TIMEOUT cycles without reaching the target, force `cnt_ent`=00, go to IDLE, and pulse `done` with `status`=10.
  - This protects against a counter that is stuck or not connected.
- Not defined: no timer logic; RUN waits indefinitely and `status` is never 10.

## Structure
- Package `counter_ctrl_pkg` holds:
  - state enum (IDLE, RUN, DWELL);
  - `cnt_ent` codes CNT_UP=2'b10, CNT_DN=2'b01, CNT_HOLD=2'b00;
  - status codes ST_OK, ST_ABORT, ST_TIMEOUT.
- Sub-module `counter_ctrl_timer`: loadable down-counter with a zero flag. It is shared for dwell and, when enabled, for timeout; they are never active together.

## Test plan
- Reset with `cnt`=0; command up, target 5, dwell 0 → `cnt_ent`=10 for 5 cycles; `cnt` stops at 5; `done`=1 with `status`=00 at cycle 6 after accept; `cnt_ent` returns to 00.
- `cnt`=60, command up, target 2, dwell 3 → `cnt` goes 61,62,63,0,1,2 and holds at 2 for 3 cycles; `done` at cycle 10 after accept.
- `cnt`=10, command down, target 10 → no counting; `done` 1 cycle after accept, `status`=00.
- `cnt`=0, command down, target 40; `abort` at the 4th RUN cycle → `cnt` stops at 61 (0→63,62,61); `done` with `status`=01 the next cycle; `busy` drops.
- `rst` pulled low mid-RUN → `cnt_ent`=00 and IDLE next cycle, no `done`; a new command is accepted after `rst` returns high. Also check that `cmd_valid` held through the previous command is accepted in the `done` cycle.
- With `CNT_CTRL_TIMEOUT_EN`, the counter model frozen, command up, target 7 → after 80 RUN cycles, `done` with `status`=10 and `cnt_ent`=00.
